program_counter: RTL and testbench



---
 rtl/nibbler_pkg.sv | 8 +
 rtl/program_counter.sv | 42 ++++
 tb/tb_program_counter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/nibbler_pkg.sv
// Shared Nibbler CPU definitions: program address width and address type.
package nibbler_pkg;

  localparam int ADDR_W = 12;

  typedef logic [ADDR_W-1:0] addr_t;

endpackage : nibbler_pkg

// File: rtl/program_counter.sv
// Nibbler fetch-address register. On each edge it resets, loads a jump target,
// steps by one (wrapping modulo 2^WIDTH), or holds. The priority is Rst > load > inc.
module program_counter
  import nibbler_pkg::*;
#(
  parameter int WIDTH = ADDR_W
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] newaddr,
  input  logic             loadPC,
  input  logic             incPC,
  output logic [WIDTH-1:0] addr
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  // Next-address select: a load wins over an increment, and neither means hold.
  always_comb begin
    pc_d = pc_q;
    if (loadPC) begin
      pc_d = newaddr;
    end else if (incPC) begin
      pc_d = pc_q + WIDTH'(1);
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register with synchronous reset overriding every other action.
  always_ff @(posedge clk) begin
    if (Rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign addr = pc_q;

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Randomised plus directed scoreboard bench for program_counter: the driver queues
// the expected address per edge, and a monitor on the falling edge compares it.
module tb_program_counter;

  localparam int W = 12;

  logic          clk;
  logic          Rst;
  logic [W-1:0]  newaddr;
  logic          loadPC;
  logic          incPC;
  logic [W-1:0]  addr;

  typedef struct {
    logic [W-1:0] exp;
    string        name;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       n_checks;
  int       n_fail;
  int       model_pc;

  program_counter #(.WIDTH(W)) dut (
    .clk     (clk),
    .Rst     (Rst),
    .newaddr (newaddr),
    .loadPC  (loadPC),
    .incPC   (incPC),
    .addr    (addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one edge's worth of inputs and queue the address expected after that edge.
  task automatic step(input logic r, input logic ld, input logic inc,
                      input logic [W-1:0] na, input string nm);
    sb_item_t it;
    Rst     = r;
    loadPC  = ld;
    incPC   = inc;
    newaddr = na;
    @(posedge clk);
    if (r)        model_pc = 0;
    else if (ld)  model_pc = int'(na);
    else if (inc) model_pc = (model_pc + 1) % 4096;
    it.exp  = model_pc[W-1:0];
    it.name = nm;
    sb_q.push_back(it);
    @(negedge clk);
  endtask

  // Monitor: compare the registered address with the oldest queued expectation.
  always @(negedge clk) begin
    sb_item_t it;
    if (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      n_checks++;
      if (addr !== it.exp) begin
        n_fail++;
        $display("FAIL %s: addr=0x%03h expected=0x%03h", it.name, addr, it.exp);
      end
    end
  end

  initial begin
    int drain;
    logic [W-1:0] na;
    n_checks = 0;
    n_fail   = 0;
    model_pc = 0;
    Rst = 1'b0; loadPC = 1'b0; incPC = 1'b0; newaddr = 12'h000;
    @(negedge clk);

    // Reset with inc requested, then held for several edges.
    step(1'b1, 1'b0, 1'b1, 12'h000, "reset");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 12'h7A5, "reset_held");
    // Count 1..5.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 12'h000, "count");
    // Load wins over inc, loads exactly newaddr.
    step(1'b0, 1'b1, 1'b1, 12'h359, "load_prio");
    step(1'b0, 1'b0, 1'b1, 12'hFFF, "after_load1");
    step(1'b0, 1'b0, 1'b1, 12'h000, "after_load2");
    // Hold at 0x123, newaddr ignored when not loading.
    step(1'b0, 1'b1, 1'b0, 12'h123, "load_123");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 12'hABC, "hold");
    step(1'b0, 1'b0, 1'b1, 12'h000, "resume_inc");
    // Wrap.
    step(1'b0, 1'b1, 1'b0, 12'hFFE, "load_ffe");
    step(1'b0, 1'b0, 1'b1, 12'h000, "inc_fff");
    step(1'b0, 1'b0, 1'b1, 12'h000, "wrap_000");
    step(1'b0, 1'b0, 1'b1, 12'h000, "post_wrap");
    // Reset beats load, then load takes.
    step(1'b1, 1'b1, 1'b1, 12'hABC, "rst_over_load");
    step(1'b0, 1'b1, 1'b0, 12'hABC, "load_abc");
    // Reset mid-count, then counting resumes from 0.
    step(1'b0, 1'b0, 1'b1, 12'h000, "count_abd");
    step(1'b1, 1'b0, 1'b1, 12'h000, "rst_mid_count");
    step(1'b0, 1'b0, 1'b1, 12'h000, "count_from_0");

    // Randomised traffic, biased so wrap-around gets exercised.
    for (int i = 0; i < 400; i++) begin
      na = W'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) == 0) na = 12'hFF0 | W'($urandom_range(0, 15));
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 1), na, "random");
    end

    Rst = 1'b0; loadPC = 1'b0; incPC = 1'b0;
    drain = 0;
    while (sb_q.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: pending=%0d expected=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_program_counter
